// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

    typedef enum logic {
        FETCH     = 1'b0,
        MISS_WAIT = 1'b1
    } fetch_state_t;

    localparam int          WORD_BYTES           = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    // The extra bit lets the counter hold MISS_TIMEOUT itself when it is a power of two.
    function automatic int miss_cnt_w(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Next-PC mux: hold, sequential advance, or apply a selected word-aligned target.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] target_i,
    input  logic        apply_i,
    input  logic        hold_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc_plus4_o
);

    // Plain 32-bit add: the wrap from FFFFFFFC to 00000000 is intentional.
    assign pc_plus4_o = pc_i + 32'(WORD_BYTES);

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (apply_i) begin
            next_pc_o = target_i;
        end else if (hold_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: arbitrates redirect, stall and I-cache miss, tracks miss timeout.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          MISS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        PCsrc_E,
    input  logic [31:0] PCTarget_E,
    input  logic        icache_hit,
    output logic [31:0] PC_F,
    output logic [31:0] PCPlus4_F,
    output logic        fetch_valid,
    output logic        flush_D,
    output logic        fetch_err
);

    localparam int             CNT_W   = miss_cnt_w(MISS_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MISS_TIMEOUT);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [31:0] tgt_aligned;
    logic [31:0] sel_target;
    logic        apply_sel;
    logic        hold_sel;
    logic        fv_raw;
    logic        flush_raw;

    assign tgt_aligned = PCTarget_E & ~32'h0000_0003;

    pc_next_sel u_pc_next_sel (
        .pc_i       (pc_q),
        .target_i   (sel_target),
        .apply_i    (apply_sel),
        .hold_i     (hold_sel),
        .next_pc_o  (pc_d),
        .pc_plus4_o (PCPlus4_F)
    );

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        sel_target = tgt_aligned;
        apply_sel  = 1'b0;
        hold_sel   = 1'b1;
        fv_raw     = 1'b0;
        flush_raw  = 1'b0;

        unique case (state_q)
            FETCH: begin
                cnt_d = '0;
                if (PCsrc_E) begin
                    apply_sel = 1'b1;
                    flush_raw = 1'b1;
                end else if (stall_F) begin
                    hold_sel = 1'b1;
                end else if (!icache_hit) begin
                    state_d = MISS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    hold_sel = 1'b0;
                    fv_raw   = 1'b1;
                end
            end
            MISS_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (icache_hit) begin
                    state_d    = FETCH;
                    pend_vld_d = 1'b0;
                    if (PCsrc_E) begin
                        apply_sel = 1'b1;
                        flush_raw = 1'b1;
                    end else if (pend_vld_q) begin
                        // Refilled line belongs to the squashed path, so nothing is issued.
                        sel_target = pend_tgt_q;
                        apply_sel  = 1'b1;
                    end else if (!stall_F) begin
                        hold_sel = 1'b0;
                        fv_raw   = 1'b1;
                    end
                end else if (PCsrc_E) begin
                    pend_tgt_d = tgt_aligned;
                    pend_vld_d = 1'b1;
                    flush_raw  = 1'b1;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        err_d = err_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Pending target is meaningful only while pend_vld_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

    assign PC_F        = pc_q;
    assign fetch_valid = fv_raw & ~rst;
    assign flush_D     = flush_raw & ~rst;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with MISS_TIMEOUT overridden to 4.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_F;
    logic        PCsrc_E;
    logic [31:0] PCTarget_E;
    logic        icache_hit;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;
    logic        fetch_valid;
    logic        flush_D;
    logic        fetch_err;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_sequencer #(
        .RESET_VECTOR (32'hBFC0_0000),
        .MISS_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_F     (stall_F),
        .PCsrc_E     (PCsrc_E),
        .PCTarget_E  (PCTarget_E),
        .icache_hit  (icache_hit),
        .PC_F        (PC_F),
        .PCPlus4_F   (PCPlus4_F),
        .fetch_valid (fetch_valid),
        .flush_D     (flush_D),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_F = 1'b0; PCsrc_E = 1'b0; PCTarget_E = '0; icache_hit = 1'b1;
        tick(); tick();
        chk("rst_pc",    PC_F,        32'hBFC0_0000);
        chk("rst_fv",    fetch_valid, 32'd0);
        chk("rst_flush", flush_D,     32'd0);
        chk("rst_err",   fetch_err,   32'd0);

        // Sequential run
        rst = 1'b0; #1;
        chk("seq_fv0",  fetch_valid, 32'd1);
        chk("seq_p4_0", PCPlus4_F,   32'hBFC0_0004);
        tick(); chk("seq_pc1", PC_F, 32'hBFC0_0004);
        tick(); chk("seq_pc2", PC_F, 32'hBFC0_0008);
        tick(); chk("seq_pc3", PC_F, 32'hBFC0_000C);
        chk("seq_fv3", fetch_valid, 32'd1);
        tick(); chk("seq_pc4", PC_F, 32'hBFC0_0010);

        // Redirect beats stall, target low bits dropped
        PCsrc_E = 1'b1; PCTarget_E = 32'hBFC0_0103; stall_F = 1'b1; #1;
        chk("rs_flush", flush_D,     32'd1);
        chk("rs_fv",    fetch_valid, 32'd0);
        tick();
        PCsrc_E = 1'b0; stall_F = 1'b0;
        chk("rs_pc", PC_F, 32'hBFC0_0100);

        // Move to BFC00020 then redirect during a miss
        PCsrc_E = 1'b1; PCTarget_E = 32'hBFC0_0020;
        tick();
        PCsrc_E = 1'b0;
        chk("m_pc0", PC_F, 32'hBFC0_0020);
        icache_hit = 1'b0; #1;
        chk("m1_fv", fetch_valid, 32'd0);
        tick();
        PCsrc_E = 1'b1; PCTarget_E = 32'hBFC0_0200; #1;
        chk("m2_flush", flush_D,     32'd1);
        chk("m2_fv",    fetch_valid, 32'd0);
        tick();
        PCsrc_E = 1'b0; #1;
        chk("m3_fv", fetch_valid, 32'd0);
        chk("m3_pc", PC_F,        32'hBFC0_0020);
        tick();
        chk("m4_fv",  fetch_valid, 32'd0);
        chk("m4_err", fetch_err,   32'd0);
        tick();
        chk("m5_pc",  PC_F,      32'hBFC0_0020);
        chk("m5_err", fetch_err, 32'd1);
        icache_hit = 1'b1; #1;
        chk("mh_fv",    fetch_valid, 32'd0);
        chk("mh_flush", flush_D,     32'd0);
        tick();
        chk("mr_pc", PC_F,        32'hBFC0_0200);
        chk("mr_fv", fetch_valid, 32'd1);

        // Timeout: six miss cycles, error on the fourth MISS_WAIT cycle
        rst = 1'b1; tick(); tick();
        chk("to_rst_err", fetch_err, 32'd0);
        rst = 1'b0; icache_hit = 1'b0;
        tick(); chk("to_c2", fetch_err, 32'd0);
        tick(); chk("to_c3", fetch_err, 32'd0);
        tick(); chk("to_c4", fetch_err, 32'd0);
        tick(); chk("to_c5", fetch_err, 32'd1);
        tick(); chk("to_c6", fetch_err, 32'd1);
        icache_hit = 1'b1; #1;
        chk("to_hit_fv", fetch_valid, 32'd1);
        tick();
        chk("to_after_err", fetch_err, 32'd1);
        chk("to_after_pc",  PC_F,      32'hBFC0_0004);
        rst = 1'b1; tick();
        chk("to_clr_err", fetch_err, 32'd0);

        // Wrap-around
        rst = 1'b0; PCsrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFE;
        tick();
        PCsrc_E = 1'b0;
        chk("wr_pc",  PC_F,      32'hFFFF_FFFC);
        chk("wr_p4",  PCPlus4_F, 32'h0000_0000);
        tick();
        chk("wr_pc2", PC_F,      32'h0000_0000);
        chk("wr_p42", PCPlus4_F, 32'h0000_0004);

        // Reset during a miss discards the pending redirect
        icache_hit = 1'b0;
        tick();
        PCsrc_E = 1'b1; PCTarget_E = 32'hBFC0_0300;
        tick();
        PCsrc_E = 1'b0; rst = 1'b1;
        tick(); tick();
        chk("rm_pc", PC_F, 32'hBFC0_0000);
        rst = 1'b0; icache_hit = 1'b1; #1;
        chk("rm_fv", fetch_valid, 32'd1);
        tick();
        chk("rm_pc2", PC_F, 32'hBFC0_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the fetch-stage program counter register and sequences next-PC selection.
- Sources: sequential (PC+4), resolved branch/jump target from Execute, or hold.
- Arbitrates between pipeline stall, control redirect and instruction-cache miss.
- Issues the fetch-valid qualifier and the Decode flush; sits between the hazard unit, the Execute-stage branch logic and the instruction cache.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- MISS_TIMEOUT, 64, cycles in MISS_WAIT before fetch_err is raised.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- stall_F  input  1  hazard unit: hold PC, suppress fetch.
- PCsrc_E  input  1  Execute: taken branch or jump this cycle.
- PCTarget_E  input  32  redirect target from Execute.
- icache_hit  input  1  instruction at PC_F is available this cycle.
- PC_F  output  32  current fetch address, registered.
- PCPlus4_F  output  32  PC_F + 4, combinational, 32-bit wrap.
- fetch_valid  output  1  instruction at PC_F may enter Decode this cycle.
- flush_D  output  1  squash the Decode-stage instruction, combinational.
- fetch_err  output  1  sticky miss-timeout error.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - PC_F = RESET_VECTOR; fetch_valid = 0; flush_D = 0; fetch_err = 0.
  - State = FETCH; pending-redirect valid = 0; miss counter = 0.
- States: FETCH, MISS_WAIT.
- Targets: PCTarget_E[1:0] are forced to 0 before use. PC_F[1:0] is always 0.
- FETCH priority, highest first:
  1. PCsrc_E=1: PC_F <= target; flush_D=1; fetch_valid=0. Stay in FETCH. This wins over stall_F and a miss.
  2. stall_F=1: PC_F holds; fetch_valid=0. Stay in FETCH.
  3. icache_hit=0: PC_F holds; fetch_valid=0; go to MISS_WAIT; miss counter <= 1.
  4. Otherwise: fetch_valid=1; PC_F <= PC_F+4.
- MISS_WAIT:
  - Each cycle while in this state:
    - fetch_valid=0; PC_F holds.
    - Miss counter increments and saturates at MISS_TIMEOUT.
  - PCsrc_E=1: latch the target into the pending register and assert flush_D=1. A later PCsrc_E overwrites the pending target (youngest wins).
  - icache_hit=1 with pending valid: PC_F <= pending target; clear pending; go to FETCH; fetch_valid=0, because the refilled line is discarded.
  - icache_hit=1 with no pending and stall_F=0: fetch_valid=1; PC_F <= PC_F+4; go to FETCH.
  - icache_hit=1 with no pending and stall_F=1: go to FETCH and hold PC_F. The access is re-evaluated next cycle.
  - PCsrc_E together with icache_hit in the same cycle: the new target is applied directly, any pending target is dropped, and flush_D=1.
- Timeout: when the miss counter reaches MISS_TIMEOUT, fetch_err <= 1. It stays set until rst. Operation continues.
- Wrap-around: PC_F 32'hFFFF_FFFC + 4 gives 32'h0000_0000, with no flag.
- Reset mid-miss: rst takes precedence in any state and discards the pending redirect and counter.
- Latency:
  - A redirect becomes visible on PC_F the cycle after PCsrc_E.
  - During a miss, the redirect becomes visible the cycle after icache_hit.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {FETCH, MISS_WAIT};
  - constants WORD_BYTES = 4 and DEFAULT_RESET_VECTOR;
  - width of the miss counter, derived as clog2(MISS_TIMEOUT)+1.
- One sub-module, pc_next_sel:
  - combinational;
  - takes PC_F, the aligned target, a pending-apply select and a hold select;
  - produces next_pc and PCPlus4_F.
- The FSM, pending register and counter stay in fetch_sequencer.

Test Plan:
1. Sequential run: rst for 2 cycles, then icache_hit=1 with no stalls. Required: PC_F = BFC00000, BFC00004, BFC00008, BFC0000C, with fetch_valid=1 from the first post-reset cycle.
2. Redirect versus stall: at PC_F=BFC00010, drive PCsrc_E=1, PCTarget_E=BFC00103 and stall_F=1. Required: flush_D=1 that cycle; next PC_F=BFC00100.
3. Redirect during miss: at PC_F=BFC00020, drop icache_hit for 5 cycles and pulse PCsrc_E with PCTarget_E=BFC00200 on miss cycle 2. Required:
   - flush_D=1 on that cycle;
   - fetch_valid=0 throughout, including the hit cycle;
   - PC_F=BFC00200 the cycle after the hit.
4. Timeout: with MISS_TIMEOUT=4, hold icache_hit=0 for 6 cycles. Required: fetch_err rises on the 4th MISS_WAIT cycle, stays 1 after the hit, and clears only on rst.
5. Wrap-around: redirect to FFFFFFFC, then one hit. Required: PC_F=00000000 and PCPlus4_F=00000004.
6. Reset mid-miss: enter MISS_WAIT with a pending target of BFC00300, then assert rst. Required: PC_F=BFC00000, pending cleared, and a subsequent hit does not jump to BFC00300.
